// File: rtl/pattern_detector_param.sv
// Parametrised serial pattern detector.
// Samples one bit per qualified clock and compares the last PAT_LEN bits against a
// run-time loadable pattern. y is a registered one-cycle match pulse.
// Overlapping and non-overlapping detection are both supported.
// Optional feature: define PATDET_MATCH_COUNT_EN to build the saturating match counter.
// Without that macro, match_cnt is tied to zero.
module pattern_detector_param #(
  parameter int unsigned                PAT_LEN = 4,
  parameter logic        [PAT_LEN-1:0] PATTERN = 4'b1101,
  parameter int unsigned                CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               a,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int unsigned FW = $clog2(PAT_LEN + 1);

  // Only the newest PAT_LEN-1 bits are kept: the oldest bit of a PAT_LEN window
  // shifts out on the very edge it would be compared, so it is never observed.
  logic [PAT_LEN-1:0] r_pat;
  logic [PAT_LEN-2:0] r_hist;
  logic [FW-1:0]      r_fill;
  logic               r_y;

  logic [PAT_LEN-1:0] w_pat_nxt;
  logic [PAT_LEN-2:0] w_hist_nxt;
  logic [FW-1:0]      w_fill_nxt;
  logic               w_y_nxt;
  logic [PAT_LEN-1:0] w_window;
  logic               w_match;

  // Window formed by the stored history plus the bit being sampled this cycle.
  assign w_window = {r_hist, a};
  assign w_match  = in_valid && !pat_load
                    && (r_fill >= FW'(PAT_LEN - 1))
                    && (w_window == r_pat);

  // Next-state for pattern, history, fill level and match pulse; pat_load wins.
  always_comb begin
    w_pat_nxt  = r_pat;
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    w_y_nxt    = 1'b0;
    if (pat_load) begin
      w_pat_nxt  = pat_in;
      w_hist_nxt = '0;
      w_fill_nxt = '0;
    end else if (in_valid) begin
      w_hist_nxt = w_window[PAT_LEN-2:0];
      if (r_fill != FW'(PAT_LEN)) begin
        w_fill_nxt = r_fill + FW'(1);
      end
      if (w_match) begin
        w_y_nxt = 1'b1;
        // Non-overlapping mode: require a full fresh window before the next match.
        if (!overlap) begin
          w_fill_nxt = '0;
        end
      end
    end
  end

  // State registers with asynchronous reset to the power-on pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat  <= PATTERN;
      r_hist <= '0;
      r_fill <= '0;
      r_y    <= 1'b0;
    end else begin
      r_pat  <= w_pat_nxt;
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
      r_y    <= w_y_nxt;
    end
  end

  assign y = r_y;

`ifdef PATDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Saturating match counter, cleared by a pattern load.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (pat_load) begin
      w_cnt_nxt = '0;
    end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign match_cnt = r_cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_pattern_detector_param.sv
// Self-checking bench for pattern_detector_param.
// Two instances share one input stream: the default 4-bit/1101 build and a
// 2-bit/11 build with a 2-bit counter. A queue-based model checks both every cycle,
// and the directed sequences also carry hand-computed literal expectations.
module tb_pattern_detector_param;

`ifdef PATDET_MATCH_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       in_valid = 1'b0;
  logic       a        = 1'b0;
  logic       overlap  = 1'b1;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in0  = 4'b1101;
  logic [1:0] pat_in1  = 2'b11;
  logic       y0, y1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pattern_detector_param u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in0),
    .y         (y0),
    .match_cnt (cnt0)
  );

  pattern_detector_param #(
    .PAT_LEN (2),
    .PATTERN (2'b11),
    .CNT_W   (2)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in1),
    .y         (y1),
    .match_cnt (cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Each queue holds the bits received since the last restart (reset, load, or a
  // non-overlapping match); a match is the newest len bits equalling the pattern.
  bit         q0[$];
  bit         q1[$];
  logic [3:0] mp0;
  logic [1:0] mp1;
  bit         my0, my1;
  int         mc0, mc1;

  function automatic bit tail_eq(input bit q[$], input int len, input logic [31:0] pat);
    for (int i = 0; i < len; i++) begin
      if (q[q.size() - len + i] != pat[len - 1 - i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step();
    if (rst) begin
      q0.delete(); q1.delete();
      mp0 = 4'b1101; mp1 = 2'b11;
      my0 = 0; my1 = 0; mc0 = 0; mc1 = 0;
    end else if (pat_load) begin
      q0.delete(); q1.delete();
      mp0 = pat_in0; mp1 = pat_in1;
      my0 = 0; my1 = 0; mc0 = 0; mc1 = 0;
    end else if (in_valid) begin
      q0.push_back(a);
      if (q0.size() > 4) void'(q0.pop_front());
      my0 = (q0.size() == 4) && tail_eq(q0, 4, 32'(mp0));
      if (my0) begin
        if (CntEn && mc0 < 255) mc0++;
        if (!overlap) q0.delete();
      end
      q1.push_back(a);
      if (q1.size() > 2) void'(q1.pop_front());
      my1 = (q1.size() == 2) && tail_eq(q1, 2, 32'(mp1));
      if (my1) begin
        if (CntEn && mc1 < 3) mc1++;
        if (!overlap) q1.delete();
      end
    end else begin
      my0 = 0; my1 = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Compare both instances against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("model_y0", 32'(y0), 32'(my0));
      chk("model_cnt0", 32'(cnt0), 32'(mc0));
      chk("model_y1", 32'(y1), 32'(my1));
      chk("model_cnt1", 32'(cnt1), 32'(mc1));
    end
  end

  // ---------------- stimulus ----------------
  // Inputs change 2 time units after a rising edge; outputs are read at the same point.
  task automatic send(input bit b);
    in_valid = 1'b1;
    a        = b;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    pat_load = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic load(input logic [3:0] p);
    pat_in0  = p;
    pat_load = 1'b1;
    in_valid = 1'b1;
    a        = 1'b1;
    @(posedge clk);
    #2;
    pat_load = 1'b0;
    in_valid = 1'b0;
  endtask

  // Send n bits (MSB first) and check y0 after each against the expected vector.
  task automatic run(input string tag, input bit [15:0] bits, input bit [15:0] expy,
                     input int n);
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i]);
      chk($sformatf("%s_y_bit%0d", tag, n - i), 32'(y0), 32'(expy[i]));
    end
  endtask

  initial begin
    do_reset();
    chk("reset_y", 32'(y0), 32'd0);
    chk("reset_cnt", 32'(cnt0), 32'd0);

    // Overlapping: 1101101 matches after bits 4 and 7.
    overlap = 1'b1;
    run("t1", 16'b1101101, 16'b0001001, 7);
    chk("t1_cnt", 32'(cnt0), CntEn ? 32'd2 : 32'd0);

    // Non-overlapping: same stream, only the first match.
    do_reset();
    overlap = 1'b0;
    run("t2", 16'b1101101, 16'b0001000, 7);
    chk("t2_cnt", 32'(cnt0), CntEn ? 32'd1 : 32'd0);

    // Leading extra 1 tolerated.
    do_reset();
    overlap = 1'b1;
    run("t3a", 16'b11101, 16'b00001, 5);

    // Stall of three cycles between bits 2 and 3.
    do_reset();
    run("t3b", 16'b11, 16'b00, 2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      chk($sformatf("t3b_gap%0d_y", i), 32'(y0), 32'd0);
    end
    run("t3c", 16'b01, 16'b01, 2);

    // Pattern load discards partial history.
    do_reset();
    overlap = 1'b0;
    run("t4a", 16'b110, 16'b000, 3);
    load(4'b0110);
    chk("t4_load_y", 32'(y0), 32'd0);
    chk("t4_load_cnt", 32'(cnt0), 32'd0);
    run("t4b", 16'b0110, 16'b0001, 4);
    run("t4c", 16'b1101, 16'b0000, 4);
    chk("t4_cnt", 32'(cnt0), CntEn ? 32'd1 : 32'd0);

    // Reset mid-stream restores pattern 1101 and discards history.
    do_reset();
    overlap = 1'b1;
    run("t5a", 16'b110, 16'b000, 3);
    do_reset();
    chk("t5_rst_y", 32'(y0), 32'd0);
    chk("t5_rst_cnt", 32'(cnt0), 32'd0);
    run("t5b", 16'b1, 16'b0, 1);
    run("t5c", 16'b1101, 16'b0001, 4);
    chk("t5_cnt", 32'(cnt0), CntEn ? 32'd1 : 32'd0);

    // Two-bit all-ones pattern: back-to-back pulses and counter saturation.
    do_reset();
    overlap = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(1'b1);
      chk($sformatf("t6_y1_bit%0d", i + 1), 32'(y1), (i >= 1) ? 32'd1 : 32'd0);
      chk($sformatf("t6_cnt1_bit%0d", i + 1), 32'(cnt1),
          CntEn ? 32'((i > 3) ? 3 : i) : 32'd0);
    end
    @(posedge clk);
    #2;
    chk("t6_y1_after", 32'(y1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
